// File: rtl/led_stepper.sv
// One-hot LED position stepper driven by two synchronised buttons, with a hold-off lockout after each step.
// Build option: define LED_STEPPER_AUTOREPEAT_EN for level-triggered auto-repeat; otherwise one step per press.
module led_stepper #(
  parameter int unsigned LED_COUNT      = 8,
  parameter int unsigned HOLDOFF_CYCLES = 15000000,
  parameter bit          WRAP           = 1'b1,
  parameter int unsigned START_POS      = 0
) (
  input  logic                         clk_100mhz,
  input  logic                         rst_n,
  input  logic                         btn_left,
  input  logic                         btn_right,
  output logic [LED_COUNT-1:0]         led_out,
  output logic [$clog2(LED_COUNT)-1:0] pos,
  output logic                         busy,
  output logic                         limit_hit
);

  localparam int unsigned PW = $clog2(LED_COUNT);
  localparam logic [PW-1:0]        POS_MAX   = PW'(LED_COUNT - 1);
  localparam logic [PW-1:0]        POS_RST   = PW'(START_POS);
  localparam logic [31:0]          HOLD_LOAD = 32'(HOLDOFF_CYCLES);
  localparam logic [LED_COUNT-1:0] LED_RST   = {{(LED_COUNT-1){1'b0}}, 1'b1} << START_POS;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [31:0]          cnt_q, cnt_d;
  logic [PW-1:0]        pos_q, pos_d;
  logic [LED_COUNT-1:0] led_q, led_d;
  logic                 limit_q, limit_d;
  logic [1:0]           meta_q, sync_q;
  logic [1:0]           trig;
  logic [1:0]           fire;
  logic                 want_left, want_right;
  logic                 accept;

  // Bit 0 tracks the left button, bit 1 the right button.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 2'b00;
      sync_q <= 2'b00;
    end else begin
      meta_q <= {btn_right, btn_left};
      sync_q <= meta_q;
    end
  end

`ifdef LED_STEPPER_AUTOREPEAT_EN
  assign trig = sync_q;
`else
  logic [1:0] arm_q, arm_d;

  // An arm flag re-arms while its button is released and drops on any step attempt.
  for (genvar gi = 0; gi < 2; gi++) begin : g_arm
    assign arm_d[gi] = !sync_q[gi] ? 1'b1 : (fire[gi] ? 1'b0 : arm_q[gi]);
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      arm_q <= 2'b11;
    end else begin
      arm_q <= arm_d;
    end
  end

  assign trig = sync_q & arm_q;
`endif

  assign want_left  = trig[0] & ~sync_q[1];
  assign want_right = trig[1] & ~sync_q[0];

  // State register
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pos_q   <= POS_RST;
      led_q   <= LED_RST;
      limit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      led_q   <= led_d;
      limit_q <= limit_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    limit_d = 1'b0;
    fire    = 2'b00;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (want_left) begin
          fire[0] = 1'b1;
          if (pos_q != POS_MAX) begin
            pos_d  = pos_q + 1'b1;
            accept = 1'b1;
          end else if (WRAP) begin
            pos_d  = '0;
            accept = 1'b1;
          end else begin
            limit_d = 1'b1;
          end
        end else if (want_right) begin
          fire[1] = 1'b1;
          if (pos_q != '0) begin
            pos_d  = pos_q - 1'b1;
            accept = 1'b1;
          end else if (WRAP) begin
            pos_d  = POS_MAX;
            accept = 1'b1;
          end else begin
            limit_d = 1'b1;
          end
        end
        if (accept) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end
      HOLD: begin
        cnt_d = cnt_q - 32'd1;
        if (cnt_q <= 32'd1) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // The LED vector is decoded from the next position so it is registered alongside pos.
  for (genvar gi = 0; gi < LED_COUNT; gi++) begin : g_led
    assign led_d[gi] = (pos_d == PW'(gi));
  end

  // Output logic
  always_comb begin
    busy      = (state_q == HOLD);
    limit_hit = limit_q;
    pos       = pos_q;
    led_out   = led_q;
  end

endmodule
